mips_ctrl_fsm: RTL and testbench
================================

// Module: mips_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the Mini-MIPS core. Fetches one instruction at a time over a
//  req/ack instruction-memory handshake and latches it onto `instruction`. Pulses `alu` for one cycle
//  per instruction, waits on `alu_busy` for multi-cycle ops, and sequences data-memory access and
//  register write-back. Owns the PC, branch/jump redirection, a retired-instruction counter and a
//  fetch watchdog.
// PARAMETERS
//  PC_W      32   PC / memory address width (>=8, multiple of 4 alignment assumed by design)
//  RESET_PC  0    PC value loaded on rst
//  TIMEOUT   255  max cycles to wait for imem_ack/dmem_ack before error; 8-bit counter
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     leave IDLE, begin fetching at current pc
//  pc           out  PC_W  current program counter
//  imem_req     out  1     instruction fetch request, held until imem_ack
//  imem_rdata   in   32    fetched word, valid when imem_ack=1
//  imem_ack     in   1     fetch complete
//  instruction  out  32    latched instruction driven to ALU / register file
//  alu          out  1     one-cycle execute strobe to ALU
//  alu_busy     in   1     ALU multi-cycle op in progress (sampled from cycle after alu pulse)
//  alu_zero     in   1     ALU zero flag, valid when alu_busy=0 after alu pulse
//  dmem_req     out  1     data access request, held until dmem_ack
//  dmem_we      out  1     1=store (sw), 0=load (lw); valid with dmem_req
//  dmem_ack     in   1     data access complete
//  rf_we        out  1     one-cycle register-file write enable
//  retired      out  32    count of completed instructions, wraps at 2^32
//  halted       out  1     1 in HALT state
//  err          out  1     sticky; set on ack timeout or unknown opcode
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, instruction=0, retired=0; all req/strobe outputs, halted, err = 0.
//  rst has priority over every other event, including mid-handshake; pending req is dropped.
//  Opcode = instruction[31:26]: 00 R-type, 08 addi, 23 lw, 2B sw, 04 beq, 02 j, 3F halt; else illegal.
//  States / transitions (one per clk):
//   IDLE   : start=1 -> FETCH. Otherwise hold.
//   FETCH  : imem_req=1. imem_ack=1 -> instruction<=imem_rdata, pc<=pc+4, -> DECODE.
//   DECODE : 3F -> HALT; illegal -> err<=1, HALT; j -> pc<={pc[PC_W-1:28],instr[25:0],2'b00},
//            retired++, -> FETCH; else alu=1 this cycle, -> EXEC.
//   EXEC   : wait while alu_busy=1. When 0: beq -> if alu_zero pc<=pc+(sext(imm16)<<2) (pc already +4),
//            retired++, -> FETCH; lw/sw -> MEM; R-type/addi -> WB.
//   MEM    : dmem_req=1, dmem_we=(op==2B). dmem_ack=1 -> sw: retired++, -> FETCH; lw: -> WB.
//   WB     : rf_we=1 for exactly this cycle, retired++, -> FETCH.
//   HALT   : halted=1; hold until rst. start ignored.
//  Latency (ack in same cycle as req, alu_busy=0): R-type/addi 4 cycles FETCH->FETCH; lw 5; sw 4;
//   beq 3; j 2.
//  Watchdog: 8-bit counter clears on entry to FETCH/MEM, increments each cycle req held without ack;
//   reaching TIMEOUT -> err<=1, req dropped, -> HALT. ack on the TIMEOUT cycle wins (no error).
//  imem_rdata sampled only on imem_ack; ack outside FETCH/MEM is ignored.
//  PC arithmetic modulo 2^PC_W; wrap from max to 0 is legal, no error.
//  alu and rf_we never high in the same cycle; imem_req and dmem_req mutually exclusive.
// TESTING
//  1 rst, start; imem returns 0x012A4020 (add) with 1-cycle ack -> alu pulse 1 cycle, rf_we 1 cycle,
//    pc=4, retired=1, next imem_req 4 cycles after first.
//  2 beq (0x1085FFFF) at pc=0x10, alu_zero=1 -> pc=0x10; alu_zero=0 -> pc=0x14; no rf_we.
//  3 lw 0x8C880004 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, rf_we after ack.
//  4 alu_busy high 5 cycles after alu pulse -> FSM stays in EXEC, no rf_we until busy drops.
//  5 imem_ack never asserted -> err=1 and halted=1 after TIMEOUT=255 waiting cycles; start ignored.
//  6 rst asserted mid-MEM with dmem_req=1 -> next cycle dmem_req=0, pc=RESET_PC, retired=0, IDLE.

Source files
------------

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer for the Mini-MIPS core: fetch, decode, execute,
// memory and write-back sequencing with PC ownership, retire counter and ack watchdog.
module mips_ctrl_fsm #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [31:0]     instruction,
    output logic            alu,
    input  logic            alu_busy,
    input  logic            alu_zero,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic [31:0]     retired,
    output logic            halted,
    output logic            err
);

    localparam int       XW = (PC_W > 32) ? PC_W : 32;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state;
    logic [7:0]  wdog;
    logic [5:0]  op;

    assign op = instruction[31:26];

    // pc already points past the branch, so the offset is applied to pc+4
    function automatic logic [PC_W-1:0] br_target(input logic [PC_W-1:0] base,
                                                   input logic [15:0]     imm);
        logic signed [XW-1:0] off;
        off = XW'($signed({imm, 2'b00}));
        return base + off[PC_W-1:0];
    endfunction

    function automatic logic [PC_W-1:0] j_target(input logic [PC_W-1:0] base,
                                                  input logic [25:0]     idx);
        logic [XW-1:0] t;
        t       = XW'(base);
        t[27:0] = {idx, 2'b00};
        return t[PC_W-1:0];
    endfunction

    function automatic logic uses_alu(input logic [5:0] opc);
        case (opc)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Outputs are registered: each strobe is set on the edge that enters its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            retired     <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            alu         <= 1'b0;
            rf_we       <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            wdog        <= '0;
        end else begin
            alu   <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        wdog     <= '0;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        pc          <= pc + PC_W'(4);
                        imem_req    <= 1'b0;
                        alu         <= uses_alu(imem_rdata[31:26]);
                        state       <= DECODE;
                    end else if (wdog == TO) begin
                        imem_req <= 1'b0;
                        err      <= 1'b1;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                DECODE: begin
                    case (op)
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        OP_J: begin
                            pc       <= j_target(pc, instruction[25:0]);
                            retired  <= retired + 32'd1;
                            imem_req <= 1'b1;
                            wdog     <= '0;
                            state    <= FETCH;
                        end
                        OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state <= EXEC;
                        default: begin
                            err    <= 1'b1;
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    endcase
                end
                EXEC: begin
                    if (!alu_busy) begin
                        case (op)
                            OP_BEQ: begin
                                if (alu_zero) pc <= br_target(pc, instruction[15:0]);
                                retired  <= retired + 32'd1;
                                imem_req <= 1'b1;
                                wdog     <= '0;
                                state    <= FETCH;
                            end
                            OP_LW, OP_SW: begin
                                dmem_req <= 1'b1;
                                dmem_we  <= (op == OP_SW);
                                wdog     <= '0;
                                state    <= MEM;
                            end
                            default: begin
                                rf_we <= 1'b1;
                                state <= WB;
                            end
                        endcase
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_SW) begin
                            retired  <= retired + 32'd1;
                            imem_req <= 1'b1;
                            wdog     <= '0;
                            state    <= FETCH;
                        end else begin
                            rf_we <= 1'b1;
                            state <= WB;
                        end
                    end else if (wdog == TO) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        err      <= 1'b1;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                WB: begin
                    retired  <= retired + 32'd1;
                    imem_req <= 1'b1;
                    wdog     <= '0;
                    state    <= FETCH;
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: builds a per-cycle trace of stimulus and expected outputs by
// composing per-instruction phase lengths, then replays it against the DUT.
module tb_mips_ctrl_fsm;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0;
    logic        imem_ack = 1'b0, alu_busy = 1'b0, alu_zero = 1'b0, dmem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc, instruction, retired;
    logic        imem_req, alu, dmem_req, dmem_we, rf_we, halted, err;

    always #5 clk = ~clk;

    mips_ctrl_fsm #(.PC_W(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instruction(instruction), .alu(alu), .alu_busy(alu_busy), .alu_zero(alu_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .retired(retired), .halted(halted), .err(err)
    );

    typedef struct {
        bit        chk, rst, start, iack;
        bit [31:0] rdata;
        bit        busy, zero, dack;
        bit        ireq, dreq, dwe, alu, rfwe, halted, err;
        bit [31:0] pc, ret, instr;
        bit        pin;
        bit [31:0] pin_pc, pin_ret;
    } ent_t;

    ent_t      q[$];
    bit [31:0] m_pc, m_ret, m_instr;
    bit        m_err, m_halt;
    bit        pend;
    bit [31:0] pend_pc, pend_ret;
    int        total = 0, bad = 0;

    // New cycle: random don't-care inputs, outputs from the model's architectural state
    function automatic ent_t base();
        ent_t e;
        e.chk = 1; e.rst = 0;
        e.start = 1'($urandom); e.iack = 1'($urandom); e.rdata = $urandom;
        e.busy = 1'($urandom); e.zero = 1'($urandom); e.dack = 1'($urandom);
        e.ireq = 0; e.dreq = 0; e.dwe = 0; e.alu = 0; e.rfwe = 0;
        e.halted = m_halt; e.err = m_err; e.pc = m_pc; e.ret = m_ret; e.instr = m_instr;
        e.pin = 0; e.pin_pc = 0; e.pin_ret = 0;
        return e;
    endfunction

    task automatic push(input ent_t e);
        if (pend) begin
            e.pin = 1; e.pin_pc = pend_pc; e.pin_ret = pend_ret; pend = 0;
        end
        q.push_back(e);
    endtask

    task automatic reset_model();
        m_pc = 0; m_ret = 0; m_instr = 0; m_err = 0; m_halt = 0;
    endtask

    task automatic pin(input bit [31:0] pc_l, input bit [31:0] ret_l, input string nm);
        total++;
        if (m_pc !== pc_l || m_ret !== ret_l) begin
            bad++;
            $display("FAIL model_%s: model pc=%h ret=%0d required pc=%h ret=%0d",
                     nm, m_pc, m_ret, pc_l, ret_l);
        end
        pend = 1; pend_pc = pc_l; pend_ret = ret_l;
    endtask

    task automatic do_reset(input int n, input bit chk0);
        ent_t e;
        e = base(); e.rst = 1; e.chk = chk0; push(e);
        reset_model();
        for (int i = 1; i < n; i++) begin
            e = base(); e.rst = 1; push(e);
        end
    endtask

    task automatic idle_start(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = base(); e.start = 0; push(e);
        end
        e = base(); e.start = 1; push(e);
    endtask

    task automatic halt_cycles(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = base(); push(e);
        end
    endtask

    // One instruction: di = imem ack delay, b = busy cycles, dd = dmem ack delay,
    // abort = MEM cycle index on which rst is raised (-1: none)
    task automatic run(input bit [31:0] instr, input int di, input int b, input bit z,
                       input int dd, input int abort);
        ent_t     e;
        bit [5:0] op;
        bit       need, legal;
        op    = instr[31:26];
        need  = op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04};
        legal = need || op == 6'h02 || op == 6'h3F;
        if (di > TO) begin
            for (int k = 0; k <= TO; k++) begin
                e = base(); e.ireq = 1; e.iack = 0; push(e);
            end
            m_err = 1; m_halt = 1;
            return;
        end
        for (int k = 0; k <= di; k++) begin
            e = base(); e.ireq = 1; e.iack = (k == di);
            if (k == di) e.rdata = instr;
            push(e);
        end
        m_instr = instr;
        m_pc    = m_pc + 4;
        e = base(); e.alu = need; push(e);
        if (!legal) begin m_err = 1; m_halt = 1; return; end
        if (op == 6'h3F) begin m_halt = 1; return; end
        if (op == 6'h02) begin
            m_pc  = {m_pc[31:28], instr[25:0], 2'b00};
            m_ret = m_ret + 1;
            return;
        end
        for (int k = 0; k <= b; k++) begin
            e = base(); e.busy = (k < b);
            if (k == b) e.zero = z;
            push(e);
        end
        if (op == 6'h04) begin
            if (z) m_pc = m_pc + {{14{instr[15]}}, instr[15:0], 2'b00};
            m_ret = m_ret + 1;
            return;
        end
        if (op == 6'h23 || op == 6'h2B) begin
            if (dd > TO) begin
                for (int k = 0; k <= TO; k++) begin
                    e = base(); e.dreq = 1; e.dwe = (op == 6'h2B); e.dack = 0; push(e);
                end
                m_err = 1; m_halt = 1;
                return;
            end
            for (int k = 0; k <= dd; k++) begin
                e = base(); e.dreq = 1; e.dwe = (op == 6'h2B); e.dack = (k == dd);
                if (k == abort) begin
                    e.rst = 1; push(e); reset_model();
                    return;
                end
                push(e);
            end
            if (op == 6'h2B) begin m_ret = m_ret + 1; return; end
        end
        e = base(); e.rfwe = 1; push(e);
        m_ret = m_ret + 1;
    endtask

    task automatic build();
        int       i0;
        bit [5:0] ops[6];
        bit [5:0] op;
        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23;
        ops[3] = 6'h2B; ops[4] = 6'h04; ops[5] = 6'h02;
        pend = 0;
        reset_model();
        do_reset(3, 0);
        idle_start(2);

        i0 = q.size();
        run(32'h012A4020, 0, 0, 0, 0, -1);
        total++;
        if (q.size() - i0 != 4) begin
            bad++;
            $display("FAIL model_add_latency: got %0d cycles required 4", q.size() - i0);
        end
        pin(32'h4, 1, "add");

        run(32'h20010005, 0, 0, 0, 0, -1);
        run(32'h012A4020, 1, 0, 0, 0, -1);
        run(32'hAC010000, 0, 0, 0, 0, -1);
        pin(32'h10, 4, "pre_beq");
        run(32'h1085FFFF, 0, 0, 1, 0, -1);
        pin(32'h10, 5, "beq_taken");
        run(32'h1085FFFF, 0, 0, 0, 0, -1);
        pin(32'h14, 6, "beq_not");
        run(32'h8C880004, 0, 0, 0, 3, -1);
        pin(32'h18, 7, "lw");
        run(32'h012A4020, 0, 5, 0, 0, -1);
        pin(32'h1C, 8, "busy");

        for (int n = 0; n < 120; n++) begin
            op = ops[$urandom_range(0, 5)];
            run({op, 26'($urandom)},
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                1'($urandom),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, -1);
        end

        run(32'hAC010000, 0, 0, 0, 5, 2);
        pin(32'h0, 0, "mem_rst");
        idle_start(3);

        run(32'h1000FFFE, 0, 0, 1, 0, -1);
        pin(32'hFFFFFFFC, 1, "wrap_pre");
        run(32'h012A4020, 0, 0, 0, 0, -1);
        pin(32'h0, 2, "wrap");
        run(32'h012A4020, TO, 0, 0, 0, -1);
        run(32'h08000040, 0, 0, 0, 0, -1);
        pin(32'h100, 4, "jump");

        run(32'hFC000000, 0, 0, 0, 0, -1);
        halt_cycles(4);
        do_reset(2, 1);
        idle_start(1);

        run(32'h1C000000, 0, 0, 0, 0, -1);
        halt_cycles(4);
        do_reset(2, 1);
        idle_start(1);

        run(32'h8C880004, 0, 0, 0, TO + 1, -1);
        halt_cycles(3);
        do_reset(2, 1);
        idle_start(1);

        run(32'h012A4020, TO + 1, 0, 0, 0, -1);
        halt_cycles(6);
    endtask

    initial begin
        bit [6:0] act, exp;
        build();
        foreach (q[i]) begin
            @(negedge clk);
            if (q[i].chk) begin
                act = {imem_req, dmem_req, dmem_we, alu, rf_we, halted, err};
                exp = {q[i].ireq, q[i].dreq, q[i].dwe, q[i].alu, q[i].rfwe, q[i].halted, q[i].err};
                total++;
                if (act !== exp || pc !== q[i].pc || retired !== q[i].ret ||
                    instruction !== q[i].instr) begin
                    bad++;
                    $display("FAIL cyc%0d: ctl=%b pc=%h ret=%0d ins=%h required ctl=%b pc=%h ret=%0d ins=%h",
                             i, act, pc, retired, instruction,
                             exp, q[i].pc, q[i].ret, q[i].instr);
                end
            end
            if (q[i].pin) begin
                total++;
                if (pc !== q[i].pin_pc || retired !== q[i].pin_ret) begin
                    bad++;
                    $display("FAIL pin%0d: pc=%h ret=%0d required pc=%h ret=%0d",
                             i, pc, retired, q[i].pin_pc, q[i].pin_ret);
                end
            end
            rst        = q[i].rst;
            start      = q[i].start;
            imem_ack   = q[i].iack;
            imem_rdata = q[i].rdata;
            alu_busy   = q[i].busy;
            alu_zero   = q[i].zero;
            dmem_ack   = q[i].dack;
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
